// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: the default NOP encoding and the stage state type.
package fetch_stage_pkg;

  // SLL r0,r0,0 -- decodes as a no-op in the ID control unit
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Priority selection of the next PC and IF/ID update action:
// branch > stall > halt > jump > sequential.
module next_pc_sel #(
  parameter int PC_WIDTH = 32
) (
  input  logic                 branch_taken_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  input  logic                 stall_i,
  input  logic                 halt_i,
  input  logic                 jump_i,
  input  logic [PC_WIDTH-1:0]  pc_i,
  input  logic [PC_WIDTH-1:0]  pc_plus4_i,
  input  logic [PC_WIDTH-29:0] pp4_hi_i,
  input  logic [25:0]          jump_index_i,
  output logic [PC_WIDTH-1:0]  pc_next_o,
  output logic                 if_id_load_o,
  output logic                 if_id_flush_o,
  output logic                 pp4_clear_o,
  output logic                 halt_req_o
);

  always_comb begin
    pc_next_o     = pc_i;
    if_id_load_o  = 1'b0;
    if_id_flush_o = 1'b0;
    pp4_clear_o   = 1'b0;
    halt_req_o    = 1'b0;
    if (branch_taken_i) begin
      // The ID instruction is on the wrong path, so this beats stall/halt/jump.
      pc_next_o     = branch_target_i;
      if_id_flush_o = 1'b1;
      pp4_clear_o   = 1'b1;
    end else if (stall_i) begin
      pc_next_o = pc_i;
    end else if (halt_i) begin
      if_id_flush_o = 1'b1;
      halt_req_o    = 1'b1;
    end else if (jump_i) begin
      pc_next_o     = {pp4_hi_i, jump_index_i, 2'b00};
      if_id_flush_o = 1'b1;
    end else begin
      pc_next_o    = pc_plus4_i;
      if_id_load_o = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, IF/ID register, RUN/HALTED state and debug counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int          PC_WIDTH  = 32,
  parameter int          CNT_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 Enable,
  input  logic                 Stall,
  input  logic                 BranchTaken,
  input  logic [PC_WIDTH-1:0]  BranchTarget,
  input  logic                 JumpD,
  input  logic                 HaltD,
  output logic [PC_WIDTH-1:0]  ImemAddr,
  input  logic [31:0]          ImemData,
  output logic [31:0]          InstrD,
  output logic [PC_WIDTH-1:0]  PcPlus4D,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] CycleCount,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  logic [PC_WIDTH-1:0]  pc_q, pc_d, pp4_q, pp4_d, pc_plus4, pc_next;
  logic [31:0]          instr_q, instr_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d, icnt_q, icnt_d;
  fetch_state_e         state_q, state_d;
  logic                 if_id_load, if_id_flush, pp4_clear, halt_req;

  assign pc_plus4 = pc_q + PC_WIDTH'(4);

  next_pc_sel #(.PC_WIDTH(PC_WIDTH)) u_next_pc_sel (
    .branch_taken_i (BranchTaken),
    .branch_target_i(BranchTarget),
    .stall_i        (Stall),
    .halt_i         (HaltD),
    .jump_i         (JumpD),
    .pc_i           (pc_q),
    .pc_plus4_i     (pc_plus4),
    .pp4_hi_i       (pp4_q[PC_WIDTH-1:28]),
    .jump_index_i   (instr_q[25:0]),
    .pc_next_o      (pc_next),
    .if_id_load_o   (if_id_load),
    .if_id_flush_o  (if_id_flush),
    .pp4_clear_o    (pp4_clear),
    .halt_req_o     (halt_req)
  );

  always_comb begin
    pc_d    = pc_q;
    pp4_d   = pp4_q;
    instr_d = instr_q;
    cyc_d   = cyc_q;
    icnt_d  = icnt_q;
    state_d = state_q;
    // With Enable low every register holds and all redirect inputs are dropped.
    if (Enable) begin
      if (state_q == ST_RUN) begin
        cyc_d = cyc_q + CNT_WIDTH'(1);
        pc_d  = pc_next;
        if (if_id_load) begin
          instr_d = ImemData;
          pp4_d   = pc_plus4;
          icnt_d  = icnt_q + CNT_WIDTH'(1);
        end else if (if_id_flush) begin
          instr_d = NOP_INSTR;
        end
        if (pp4_clear) pp4_d = '0;
        if (halt_req) state_d = ST_HALTED;
      end else begin
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      pp4_q   <= '0;
      instr_q <= NOP_INSTR;
      cyc_q   <= '0;
      icnt_q  <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      pp4_q   <= pp4_d;
      instr_q <= instr_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
      state_q <= state_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign InstrD     = instr_q;
  assign PcPlus4D   = pp4_q;
  assign Halted     = (state_q == ST_HALTED);
  assign CycleCount = cyc_q;
  assign InstrCount = icnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Enable = 1'b0, Stall = 1'b0, BranchTaken = 1'b0, JumpD = 1'b0, HaltD = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic [31:0] ImemAddr, ImemData, InstrD, PcPlus4D, CycleCount, InstrCount;
  logic        Halted;

  logic [31:0] mem [0:1023];
  assign ImemData = mem[ImemAddr[11:2]];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pp4, m_cyc, m_icnt;
  logic        m_halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .Enable(Enable), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .JumpD(JumpD), .HaltD(HaltD),
    .ImemAddr(ImemAddr), .ImemData(ImemData), .InstrD(InstrD), .PcPlus4D(PcPlus4D),
    .Halted(Halted), .CycleCount(CycleCount), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_cyc = 0; m_icnt = 0; m_halted = 1'b0;
  endtask

  // One clock of the stage as described by the rules, using the inputs seen at the edge.
  task automatic model_step();
    if (Enable && !m_halted) begin
      m_cyc = m_cyc + 1;
      if (BranchTaken) begin
        m_pc = BranchTarget; m_instr = 0; m_pp4 = 0;
      end else if (Stall) begin
        m_pc = m_pc;
      end else if (HaltD) begin
        m_instr = 0; m_halted = 1'b1;
      end else if (JumpD) begin
        m_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
        m_instr = 0;
      end else begin
        m_instr = mem[m_pc[11:2]];
        m_pp4   = m_pc + 4;
        m_pc    = m_pc + 4;
        m_icnt  = m_icnt + 1;
      end
    end
  endtask

  task automatic drive(input logic en, input logic st, input logic br, input logic [31:0] bt,
                       input logic j, input logic h);
    Enable = en; Stall = st; BranchTaken = br; BranchTarget = bt; JumpD = j; HaltD = h;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_random(input int en_pct, input int halt_pct);
    drive(($urandom % 100) < en_pct, ($urandom % 100) < 20, ($urandom % 100) < 10,
          32'($urandom_range(0, 1023)) << 2, ($urandom % 100) < 10,
          ($urandom % 100) < halt_pct);
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ImemAddr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", ImemAddr, 32'h0); end
    n_checks++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp %h", InstrD, 32'h0); end
    n_checks++; if (PcPlus4D !== 32'h0) begin n_fail++; $display("FAIL reset_pp4 got %h exp %h", PcPlus4D, 32'h0); end
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", Halted); end
    n_checks++; if (CycleCount !== 32'h0) begin n_fail++; $display("FAIL reset_cyc got %0d exp 0", CycleCount); end
    n_checks++; if (InstrCount !== 32'h0) begin n_fail++; $display("FAIL reset_icnt got %0d exp 0", InstrCount); end
    $display("reset: pc=%h instr=%h halted=%b", ImemAddr, InstrD, Halted);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    n_checks++; if (InstrD !== 32'h20010005) begin n_fail++; $display("FAIL first_instr got %h exp %h", InstrD, 32'h20010005); end
    n_checks++; if (PcPlus4D !== 32'h4) begin n_fail++; $display("FAIL first_pp4 got %h exp %h", PcPlus4D, 32'h4); end
    n_checks++; if (ImemAddr !== 32'h4) begin n_fail++; $display("FAIL first_pc got %h exp %h", ImemAddr, 32'h4); end
    n_checks++; if (InstrCount !== 32'd1) begin n_fail++; $display("FAIL first_icnt got %0d exp 1", InstrCount); end
    $display("first_fetch: pc=%h instr=%h pp4=%h", ImemAddr, InstrD, PcPlus4D);
  endtask

  task automatic test_stall();
    logic [31:0] s_instr, s_cyc, s_icnt;
    cycle();
    s_instr = mem[1]; s_cyc = m_cyc; s_icnt = m_icnt;
    drive(1, 1, 0, 0, 0, 0);
    repeat (3) cycle();
    n_checks++; if (ImemAddr !== 32'h8) begin n_fail++; $display("FAIL stall_pc got %h exp %h", ImemAddr, 32'h8); end
    n_checks++; if (InstrD !== s_instr) begin n_fail++; $display("FAIL stall_instr got %h exp %h", InstrD, s_instr); end
    n_checks++; if (PcPlus4D !== 32'h8) begin n_fail++; $display("FAIL stall_pp4 got %h exp %h", PcPlus4D, 32'h8); end
    n_checks++; if (InstrCount !== s_icnt) begin n_fail++; $display("FAIL stall_icnt got %0d exp %0d", InstrCount, s_icnt); end
    n_checks++; if (CycleCount !== s_cyc + 3) begin n_fail++; $display("FAIL stall_cyc got %0d exp %0d", CycleCount, s_cyc + 3); end
    $display("stall: pc=%h instr=%h cyc=%0d icnt=%0d", ImemAddr, InstrD, CycleCount, InstrCount);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_jump();
    cycle();
    n_checks++; if (InstrD !== 32'h08000010) begin n_fail++; $display("FAIL jump_setup_instr got %h exp %h", InstrD, 32'h08000010); end
    n_checks++; if (PcPlus4D !== 32'hC) begin n_fail++; $display("FAIL jump_setup_pp4 got %h exp %h", PcPlus4D, 32'hC); end
    drive(1, 0, 0, 0, 1, 0);
    cycle();
    n_checks++; if (ImemAddr !== 32'h40) begin n_fail++; $display("FAIL jump_pc got %h exp %h", ImemAddr, 32'h40); end
    n_checks++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL jump_instr got %h exp %h", InstrD, 32'h0); end
    drive(1, 0, 0, 0, 0, 0);
    cycle();
    n_checks++; if (InstrD !== mem[16]) begin n_fail++; $display("FAIL jump_fetch_instr got %h exp %h", InstrD, mem[16]); end
    n_checks++; if (ImemAddr !== 32'h44) begin n_fail++; $display("FAIL jump_fetch_pc got %h exp %h", ImemAddr, 32'h44); end
    $display("jump: pc=%h instr=%h pp4=%h", ImemAddr, InstrD, PcPlus4D);
  endtask

  task automatic test_branch_priority();
    drive(1, 1, 1, 32'h100, 1, 1);
    cycle();
    n_checks++; if (ImemAddr !== 32'h100) begin n_fail++; $display("FAIL branch_pc got %h exp %h", ImemAddr, 32'h100); end
    n_checks++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL branch_instr got %h exp %h", InstrD, 32'h0); end
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL branch_halted got %b exp 0", Halted); end
    n_checks++; if (PcPlus4D !== 32'h0) begin n_fail++; $display("FAIL branch_pp4 got %h exp %h", PcPlus4D, 32'h0); end
    $display("branch_priority: pc=%h instr=%h halted=%b", ImemAddr, InstrD, Halted);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_halt();
    logic [31:0] s_cyc, s_icnt;
    drive(1, 0, 1, 32'h20, 0, 0);
    cycle();
    drive(1, 0, 0, 0, 0, 1);
    cycle();
    n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter got %b exp 1", Halted); end
    n_checks++; if (CycleCount !== m_cyc) begin n_fail++; $display("FAIL halt_enter_cyc got %0d exp %0d", CycleCount, m_cyc); end
    s_cyc = m_cyc; s_icnt = m_icnt;
    for (int i = 0; i < 10; i++) begin
      drive_random(100, 50);
      cycle();
      n_checks++; if (ImemAddr !== 32'h20) begin n_fail++; $display("FAIL halt_pc[%0d] got %h exp %h", i, ImemAddr, 32'h20); end
      n_checks++; if (InstrD !== 32'h0) begin n_fail++; $display("FAIL halt_instr[%0d] got %h exp %h", i, InstrD, 32'h0); end
      n_checks++; if (Halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag[%0d] got %b exp 1", i, Halted); end
      n_checks++; if (CycleCount !== s_cyc || InstrCount !== s_icnt) begin
        n_fail++; $display("FAIL halt_counters[%0d] got %0d/%0d exp %0d/%0d", i, CycleCount, InstrCount, s_cyc, s_icnt);
      end
    end
    $display("halt: pc=%h instr=%h halted=%b cyc=%0d", ImemAddr, InstrD, Halted, CycleCount);
  endtask

  // Called at posedge+1: asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic test_async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (ImemAddr !== 32'h0 || InstrD !== 32'h0 || PcPlus4D !== 32'h0) begin
      n_fail++; $display("FAIL %s_regs got pc=%h instr=%h pp4=%h exp all 0", tag, ImemAddr, InstrD, PcPlus4D);
    end
    n_checks++; if (Halted !== 1'b0) begin n_fail++; $display("FAIL %s_halted got %b exp 0", tag, Halted); end
    n_checks++; if (CycleCount !== 32'h0 || InstrCount !== 32'h0) begin
      n_fail++; $display("FAIL %s_counters got %0d/%0d exp 0/0", tag, CycleCount, InstrCount);
    end
    $display("%s: pc=%h instr=%h halted=%b", tag, ImemAddr, InstrD, Halted);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_enable_toggle();
    logic [31:0] p_pc, p_instr, p_pp4, p_cyc, p_icnt;
    for (int i = 0; i < 40; i++) begin
      p_pc = ImemAddr; p_instr = InstrD; p_pp4 = PcPlus4D; p_cyc = CycleCount; p_icnt = InstrCount;
      drive_random(100, 0);
      Enable = i[0];
      cycle();
      if (!Enable) begin
        n_checks++; if ({ImemAddr, InstrD, PcPlus4D, CycleCount, InstrCount} !== {p_pc, p_instr, p_pp4, p_cyc, p_icnt}) begin
          n_fail++; $display("FAIL en_hold[%0d] got pc=%h instr=%h cyc=%0d exp pc=%h instr=%h cyc=%0d", i, ImemAddr, InstrD, CycleCount, p_pc, p_instr, p_cyc);
        end
      end
      n_checks++; if ({ImemAddr, InstrD, PcPlus4D, Halted, CycleCount, InstrCount} !== {m_pc, m_instr, m_pp4, m_halted, m_cyc, m_icnt}) begin
        n_fail++; $display("FAIL en_model[%0d] got pc=%h instr=%h pp4=%h h=%b c=%0d i=%0d exp pc=%h instr=%h pp4=%h h=%b c=%0d i=%0d",
          i, ImemAddr, InstrD, PcPlus4D, Halted, CycleCount, InstrCount, m_pc, m_instr, m_pp4, m_halted, m_cyc, m_icnt);
      end
      $display("en_toggle[%0d]: en=%b pc=%h instr=%h cyc=%0d", i, Enable, ImemAddr, InstrD, CycleCount);
    end
    test_async_reset("reset_midrun");
  endtask

  task automatic test_random();
    int halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      drive_random(90, 2);
      cycle();
      n_checks++; if ({ImemAddr, InstrD, PcPlus4D, Halted, CycleCount, InstrCount} !== {m_pc, m_instr, m_pp4, m_halted, m_cyc, m_icnt}) begin
        n_fail++; $display("FAIL rand[%0d] got pc=%h instr=%h pp4=%h h=%b c=%0d i=%0d exp pc=%h instr=%h pp4=%h h=%b c=%0d i=%0d",
          i, ImemAddr, InstrD, PcPlus4D, Halted, CycleCount, InstrCount, m_pc, m_instr, m_pp4, m_halted, m_cyc, m_icnt);
      end
      $display("rand[%0d]: en=%b st=%b br=%b j=%b h=%b pc=%h instr=%h", i, Enable, Stall, BranchTaken, JumpD, HaltD, ImemAddr, InstrD);
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles > 5) begin
        test_async_reset("rand_reset");
        halted_cycles = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h20010005;
    mem[2] = 32'h08000010;
    test_reset();
    test_first_fetch();
    test_stall();
    test_jump();
    test_branch_priority();
    test_halt();
    test_async_reset("reset_halted");
    test_enable_toggle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
